// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: decodes one access into a word bus request and stalls until ack.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
`ifndef OP_LB
`define OP_LB  6'h20
`define OP_LH  6'h21
`define OP_LWL 6'h22
`define OP_LW  6'h23
`define OP_LBU 6'h24
`define OP_LHU 6'h25
`define OP_LWR 6'h26
`define OP_SB  6'h28
`define OP_SH  6'h29
`define OP_SWL 6'h2a
`define OP_SW  6'h2b
`define OP_SWR 6'h2e
`endif

module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [5:0]  i_instr_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_addr_low,
  output logic        o_addr_err,
  output logic        o_bus_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t      r_state;
  logic        r_done;
  logic [31:0] r_rdata;
  logic [1:0]  r_addr_low;
  logic        r_addr_err;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_mem_op;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [1:0]  w_off;
  logic        w_timeout;

  assign w_off = i_addr[1:0];

  // Big-endian lanes: be[3] / wdata[31:24] correspond to byte offset 0.
  always_comb begin
    w_is_load    = 1'b0;
    w_is_store   = 1'b0;
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = i_store_data;
    case (i_instr_op)
      `OP_LB, `OP_LBU, `OP_LWL, `OP_LWR: w_is_load = 1'b1;
      `OP_LH, `OP_LHU: begin
        w_is_load    = 1'b1;
        w_misaligned = w_off[0];
      end
      `OP_LW: begin
        w_is_load    = 1'b1;
        w_misaligned = |w_off;
      end
      `OP_SB: begin
        w_is_store = 1'b1;
        w_be       = 4'b1000 >> w_off;
        w_wdata    = {4{i_store_data[7:0]}};
      end
      `OP_SH: begin
        w_is_store   = 1'b1;
        w_misaligned = w_off[0];
        w_be         = w_off[1] ? 4'b0011 : 4'b1100;
        w_wdata      = {2{i_store_data[15:0]}};
      end
      `OP_SW: begin
        w_is_store   = 1'b1;
        w_misaligned = |w_off;
      end
      `OP_SWL: begin
        w_is_store = 1'b1;
        w_be       = 4'b1111 >> w_off;
        w_wdata    = i_store_data >> {w_off, 3'b000};
      end
      `OP_SWR: begin
        w_is_store = 1'b1;
        w_be       = ~(4'b0111 >> w_off);
        w_wdata    = i_store_data << {~w_off, 3'b000};
      end
      default: ;
    endcase
  end

  assign w_mem_op = w_is_load | w_is_store;
  assign o_stall  = ((r_state == ST_IDLE) & i_valid & w_mem_op) | (r_state == ST_BUSY);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
  // Fires on the BUSY cycle that would bring the no-ack count up to the limit.
  assign w_timeout = ((r_cnt + 1'b1) == CNT_W'(TIMEOUT_CYCLES));
  assign o_bus_err = r_bus_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign o_bus_err        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_done      <= 1'b0;
      r_rdata     <= '0;
      r_addr_low  <= '0;
      r_addr_err  <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
      r_cnt       <= '0;
      r_bus_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid && w_mem_op) begin
            r_addr_low <= w_off;
            if (w_misaligned) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_addr_err <= 1'b1;
            end else begin
              r_state     <= ST_BUSY;
              r_bus_req   <= 1'b1;
              r_bus_we    <= w_is_store;
              r_bus_addr  <= {i_addr[31:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
`ifdef MEM_TIMEOUT_EN
              r_cnt       <= '0;
`endif
            end
          end
        end
        ST_BUSY: begin
          if (i_bus_ack) begin
            if (!r_bus_we) begin
              r_rdata <= i_bus_rdata;
            end
            r_bus_req <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
`ifdef MEM_TIMEOUT_EN
            r_bus_err <= 1'b1;
`endif
          end else begin
`ifdef MEM_TIMEOUT_EN
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          r_done     <= 1'b0;
          r_addr_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          r_bus_err  <= 1'b0;
`endif
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_addr_low  = r_addr_low;
  assign o_addr_err  = r_addr_err;
  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_be    = r_bus_be;
  assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: completion results go through a scoreboard queue.
module tb_mem_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [5:0]  i_instr_op;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic        o_stall, o_done, o_addr_err, o_bus_err, o_bus_req, o_bus_we;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic [1:0]  o_addr_low;
  logic [3:0]  o_bus_be;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_instr_op(i_instr_op),
    .i_addr(i_addr), .i_store_data(i_store_data), .o_stall(o_stall), .o_done(o_done),
    .o_rdata(o_rdata), .o_addr_low(o_addr_low), .o_addr_err(o_addr_err),
    .o_bus_err(o_bus_err), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  low;
    logic        aerr;
    logic        berr;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // delay >= 0: ack that many cycles after req first appears; delay < 0: never ack.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] d,
                        input int delay, input logic [31:0] ack_data,
                        input logic [3:0] ebe, input logic [31:0] ewd, input logic ewe,
                        input logic misal, input logic eberr);
    exp_t e;
    exp_t got;
    @(negedge clk);
    i_valid = 1'b1; i_instr_op = op; i_addr = addr; i_store_data = d;
    #1 chk("stall_accept", o_stall, 1);
    e.rdata = (misal || ewe || eberr) ? last_rdata : ack_data;
    e.low   = addr[1:0];
    e.aerr  = misal;
    e.berr  = eberr;
    sb_q.push_back(e);
    last_rdata = e.rdata;
    @(negedge clk);
    if (!misal) begin
      chk("req_first", o_bus_req, 1);
      chk("bus_addr", o_bus_addr, {addr[31:2], 2'b00});
      chk("bus_be", o_bus_be, ebe);
      chk("bus_we", o_bus_we, ewe);
      if (ewe) chk("bus_wdata", o_bus_wdata, ewd);
      chk("stall_busy", o_stall, 1);
      chk("done_busy", o_done, 0);
      if (delay >= 0) begin
        repeat (delay) begin
          @(negedge clk);
          chk("req_hold", o_bus_req, 1);
          chk("be_hold", o_bus_be, ebe);
        end
        i_bus_ack = 1'b1; i_bus_rdata = ack_data;
      end else begin
        repeat (TO - 1) begin
          @(negedge clk);
          chk("req_hold_to", o_bus_req, 1);
        end
      end
      @(negedge clk);
      i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
    end
    chk("done_pulse", o_done, 1);
    chk("req_done", o_bus_req, 0);
    #1 chk("stall_done", o_stall, 0);
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      got = sb_q.pop_front();
      chk("rdata", o_rdata, got.rdata);
      chk("addr_low", o_addr_low, got.low);
      chk("addr_err", o_addr_err, got.aerr);
      chk("bus_err", o_bus_err, got.berr);
    end
    $display("txn op=%02h addr=%08h rdata=%08h aerr=%0b berr=%0b", op, addr, o_rdata, o_addr_err, o_bus_err);
    // i_valid still high across the DONE edge: must not start a new access.
    @(negedge clk);
    chk("done_after", o_done, 0);
    chk("req_after", o_bus_req, 0);
    chk("aerr_after", o_addr_err, 0);
    chk("berr_after", o_bus_err, 0);
    i_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_instr_op = 6'h0; i_addr = 32'h0; i_store_data = 32'h0;
    i_bus_ack = 1'b0; i_bus_rdata = 32'h0; last_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req", o_bus_req, 0);
    chk("rst_done", o_done, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_be", o_bus_be, 0);
    chk("rst_addr", o_bus_addr, 0);
    chk("rst_errs", {o_addr_err, o_bus_err}, 0);
    rst = 1'b0;

    run_op(6'h23, 32'h100, 32'h0,        2, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b0); // LW
    run_op(6'h28, 32'h203, 32'h123456AB, 0, 32'h0,        4'b0001, 32'hABABABAB, 1'b1, 1'b0, 1'b0); // SB
    run_op(6'h2a, 32'h301, 32'h11223344, 1, 32'h0,        4'b0111, 32'h00112233, 1'b1, 1'b0, 1'b0); // SWL
    run_op(6'h2e, 32'h301, 32'h11223344, 3, 32'h0,        4'b1100, 32'h33440000, 1'b1, 1'b0, 1'b0); // SWR
    run_op(6'h29, 32'h402, 32'h0000BEEF, 1, 32'h0,        4'b0011, 32'hBEEFBEEF, 1'b1, 1'b0, 1'b0); // SH
    run_op(6'h24, 32'h507, 32'h0,        0, 32'hCAFEF00D, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b0); // LBU
    run_op(6'h21, 32'h401, 32'h0,        0, 32'h0,        4'b1111, 32'h0,        1'b0, 1'b1, 1'b0); // LH mis
    run_op(6'h2b, 32'h602, 32'h0,        0, 32'h0,        4'b1111, 32'h0,        1'b1, 1'b1, 1'b0); // SW mis
    run_op(6'h23, 32'h603, 32'h0,        0, 32'h0,        4'b1111, 32'h0,        1'b0, 1'b1, 1'b0); // LW mis
    run_op(6'h2b, 32'h700, 32'h0BADF00D, 1, 32'h0,        4'b1111, 32'h0BADF00D, 1'b1, 1'b0, 1'b0); // SW
    // Ack on the timeout-limit cycle still completes normally.
    run_op(6'h26, 32'h712, 32'h0,        TO - 1, 32'h600DD00D, 4'b1111, 32'h0,   1'b0, 1'b0, 1'b0); // LWR
`ifdef MEM_TIMEOUT_EN
    run_op(6'h23, 32'h740, 32'h0,        -1, 32'h0,       4'b1111, 32'h0,        1'b0, 1'b0, 1'b1); // timeout
`else
    run_op(6'h20, 32'h741, 32'h0,        20, 32'h1234ABCD, 4'b1111, 32'h0,       1'b0, 1'b0, 1'b0); // long wait
`endif

    // Non-memory opcode: no stall, no request.
    @(negedge clk);
    i_valid = 1'b1; i_instr_op = 6'h00; i_addr = 32'h900;
    #1 chk("nonmem_stall", o_stall, 0);
    @(negedge clk);
    chk("nonmem_req", o_bus_req, 0);
    chk("nonmem_done", o_done, 0);
    i_valid = 1'b0;
    $display("txn op=00 addr=00000900 ignored");

    // Ack while idle is ignored.
    i_bus_ack = 1'b1; i_bus_rdata = 32'h55555555;
    @(negedge clk);
    i_bus_ack = 1'b0;
    chk("idle_ack_rdata", o_rdata, last_rdata);
    chk("idle_ack_done", o_done, 0);
    $display("txn idle ack ignored rdata=%08h", o_rdata);

    // Reset while BUSY, then a late ack.
    @(negedge clk);
    i_valid = 1'b1; i_instr_op = 6'h23; i_addr = 32'h800;
    @(negedge clk);
    chk("rstbusy_req", o_bus_req, 1);
    rst = 1'b1; i_valid = 1'b0;
    @(negedge clk);
    chk("rstbusy_req_drop", o_bus_req, 0);
    rst = 1'b0; i_bus_ack = 1'b1; i_bus_rdata = 32'h99999999;
    @(negedge clk);
    i_bus_ack = 1'b0;
    chk("late_ack_done", o_done, 0);
    chk("late_ack_req", o_bus_req, 0);
    chk("late_ack_rdata", o_rdata, 0);
    chk("late_ack_stall", o_stall, 0);
    @(negedge clk);
    chk("late_ack_done2", o_done, 0);
    $display("txn reset mid-busy addr=00000800 req=%0b done=%0b", o_bus_req, o_done);

    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_left observed=%0d expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
